// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_arbiter: two-port arbiter in front of a single-port 256x16 RAM |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int FIX_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_A   = 3'd2,
    S_RD_D   = 3'd3,
    S_RD_ACK = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_gnt_q, last_gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    mem_cmd_q, mem_cmd_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          grant;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;
    rdata_d    = rdata_q;

    // On a tie, round-robin favours the port that did not win last time.
    if (req0 && req1) grant = (FIX_PRIO != 0) ? 1'b0 : ~last_gnt_q;
    else              grant = req1;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d    = grant;
          last_gnt_d = grant;
          we_d       = grant ? we1    : we0;
          addr_d     = grant ? addr1  : addr0;
          wdata_d    = grant ? wdata1 : wdata0;
          state_d    = we_d ? S_WR : S_RD_A;
        end
      end
      S_WR:   state_d = S_IDLE;
      S_RD_A: state_d = S_RD_D;
      S_RD_D: begin
        rdata_d = addr_q[AW-1] ? '0 : read_data;
        state_d = S_RD_ACK;
      end
      S_RD_ACK: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    mem_cmd_d = CMD_NONE;
    case (state_d)
      S_WR:           if (!addr_d[AW-1]) mem_cmd_d = CMD_WRITE;
      S_RD_A, S_RD_D: if (!addr_d[AW-1]) mem_cmd_d = CMD_READ;
      default:        mem_cmd_d = CMD_NONE;
    endcase
    ack0_d = ((state_d == S_WR) || (state_d == S_RD_ACK)) && !owner_d;
    ack1_d = ((state_d == S_WR) || (state_d == S_RD_ACK)) &&  owner_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_cmd_q  <= CMD_NONE;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mem_cmd_q  <= mem_cmd_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign mem_cmd    = mem_cmd_q;
  assign mem_addr   = addr_q;
  assign write_data = wdata_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_port_arbiter: round-robin and fixed-priority arbiters vs model   |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  gap;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [8:0]  addr_s  [2][2];
  logic [15:0] wdata_s [2][2];
  logic        ack_s   [2][2];
  logic [15:0] rdata_s [2];
  logic [1:0]  cmd_s   [2];
  logic [8:0]  maddr_s [2];
  logic [15:0] mwd_s   [2];
  logic [15:0] rd_s    [2];
  logic        busy_s  [2];
  logic        owner_s [2];

  logic [15:0] ram    [2][256];
  logic [15:0] shadow [2][256];

  // Reference model: per DUT, the phase of the current transfer (0 = idle).
  int          ph  [2];
  int          len [2];
  logic        own [2];
  logic        mwe [2];
  logic        last[2];
  logic [8:0]  maddr[2];
  logic [15:0] mwd [2];
  logic [15:0] mrd [2];

  txn_t        tq   [4][$];
  logic        pend [2][2];

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(9), .DW(16), .FIX_PRIO(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req0(req_s[0][0]), .we0(we_s[0][0]), .addr0(addr_s[0][0]), .wdata0(wdata_s[0][0]), .ack0(ack_s[0][0]),
    .req1(req_s[0][1]), .we1(we_s[0][1]), .addr1(addr_s[0][1]), .wdata1(wdata_s[0][1]), .ack1(ack_s[0][1]),
    .rdata(rdata_s[0]), .mem_cmd(cmd_s[0]), .mem_addr(maddr_s[0]), .write_data(mwd_s[0]),
    .read_data(rd_s[0]), .busy(busy_s[0]), .owner(owner_s[0])
  );

  mem_port_arbiter #(.AW(9), .DW(16), .FIX_PRIO(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0(req_s[1][0]), .we0(we_s[1][0]), .addr0(addr_s[1][0]), .wdata0(wdata_s[1][0]), .ack0(ack_s[1][0]),
    .req1(req_s[1][1]), .we1(we_s[1][1]), .addr1(addr_s[1][1]), .wdata1(wdata_s[1][1]), .ack1(ack_s[1][1]),
    .rdata(rdata_s[1]), .mem_cmd(cmd_s[1]), .mem_addr(maddr_s[1]), .write_data(mwd_s[1]),
    .read_data(rd_s[1]), .busy(busy_s[1]), .owner(owner_s[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous-read RAM seen by each DUT.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cmd_s[d] == 2'b01) ram[d][maddr_s[d][7:0]] <= mwd_s[d];
      if (cmd_s[d] == 2'b10) rd_s[d] <= ram[d][maddr_s[d][7:0]];
    end
  end

  task automatic model_step(input int d);
    logic g;
    if (ph[d] == 0) begin
      if (req_s[d][0] || req_s[d][1]) begin
        if (req_s[d][0] && req_s[d][1]) g = (d == 1) ? 1'b0 : ~last[d];
        else                            g = req_s[d][1];
        own[d]   = g;
        last[d]  = g;
        mwe[d]   = we_s[d][g];
        maddr[d] = addr_s[d][g];
        mwd[d]   = wdata_s[d][g];
        ph[d]    = 1;
        len[d]   = mwe[d] ? 1 : 3;
        if (mwe[d] && !maddr[d][8]) shadow[d][maddr[d][7:0]] = mwd[d];
      end
    end else begin
      if (!mwe[d] && ph[d] == 2) mrd[d] = maddr[d][8] ? 16'h0 : shadow[d][maddr[d][7:0]];
      ph[d] = (ph[d] == len[d]) ? 0 : ph[d] + 1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic check_dut(input int d);
    logic       eb, ea0, ea1;
    logic [1:0] ecmd;
    eb   = (ph[d] != 0);
    ea0  = eb && (ph[d] == len[d]) && !own[d];
    ea1  = eb && (ph[d] == len[d]) &&  own[d];
    ecmd = 2'b00;
    if (eb && !maddr[d][8]) begin
      if (mwe[d])          ecmd = 2'b01;
      else if (ph[d] <= 2) ecmd = 2'b10;
    end
    check($sformatf("d%0d busy", d),    32'(busy_s[d]),   32'(eb));
    check($sformatf("d%0d ack0", d),    32'(ack_s[d][0]), 32'(ea0));
    check($sformatf("d%0d ack1", d),    32'(ack_s[d][1]), 32'(ea1));
    check($sformatf("d%0d mem_cmd", d), 32'(cmd_s[d]),    32'(ecmd));
    check($sformatf("d%0d rdata", d),   32'(rdata_s[d]),  32'(mrd[d]));
    if (ecmd != 2'b00) check($sformatf("d%0d mem_addr", d), 32'(maddr_s[d]), 32'(maddr[d]));
    if (ecmd == 2'b01) check($sformatf("d%0d write_data", d), 32'(mwd_s[d]), 32'(mwd[d]));
    if (eb)            check($sformatf("d%0d owner", d), 32'(owner_s[d]), 32'(own[d]));
  endtask

  // Requester: holds a request until its ack, then takes the next queued one.
  task automatic agent(input int d, input int p);
    int   i;
    txn_t t;
    i = d * 2 + p;
    if (pend[d][p] && ack_s[d][p]) begin
      pend[d][p]  = 1'b0;
      req_s[d][p] = 1'b0;
    end
    if (!pend[d][p] && tq[i].size() > 0) begin
      t = tq[i][0];
      if (t.gap != 8'd0) begin
        t.gap    = t.gap - 8'd1;
        tq[i][0] = t;
      end else begin
        void'(tq[i].pop_front());
        req_s[d][p]   = 1'b1;
        we_s[d][p]    = t.we;
        addr_s[d][p]  = t.addr;
        wdata_s[d][p] = t.wdata;
        pend[d][p]    = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check_dut(d);
      for (int p = 0; p < 2; p++) agent(d, p);
    end
  end

  task automatic push(input int d, input int p, input logic we, input logic [8:0] addr,
                      input logic [15:0] wdata, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.gap = 8'(gap);
    tq[d * 2 + p].push_back(t);
  endtask

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < 4; i++) n += tq[i].size();
    for (int d = 0; d < 2; d++) begin
      if (ph[d] != 0) n++;
      for (int p = 0; p < 2; p++) if (pend[d][p]) n++;
    end
    return n;
  endfunction

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (outstanding() == 0) break;
    end
    check(tag, 32'(outstanding()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; len[d] = 1; own[d] = 1'b0; mwe[d] = 1'b0; last[d] = 1'b1;
      maddr[d] = '0; mwd[d] = '0; mrd[d] = '0;
      for (int p = 0; p < 2; p++) begin
        pend[d][p] = 1'b0; req_s[d][p] = 1'b0; we_s[d][p] = 1'b0;
        addr_s[d][p] = '0; wdata_s[d][p] = '0;
      end
    end
    for (int i = 0; i < 4; i++) tq[i].delete();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst mem_cmd", d),    32'(cmd_s[d]),    32'd0);
      check($sformatf("d%0d rst busy", d),       32'(busy_s[d]),   32'd0);
      check($sformatf("d%0d rst ack0", d),       32'(ack_s[d][0]), 32'd0);
      check($sformatf("d%0d rst ack1", d),       32'(ack_s[d][1]), 32'd0);
      check($sformatf("d%0d rst rdata", d),      32'(rdata_s[d]),  32'd0);
      check($sformatf("d%0d rst mem_addr", d),   32'(maddr_s[d]),  32'd0);
      check($sformatf("d%0d rst write_data", d), 32'(mwd_s[d]),    32'd0);
      check($sformatf("d%0d rst owner", d),      32'(owner_s[d]),  32'd0);
    end
  endtask

  initial begin
    logic [15:0] v;
    clk   = 1'b0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = '0;
      for (int a = 0; a < 256; a++) begin
        v = 16'($urandom);
        ram[d][a]    = v;
        shadow[d][a] = v;
      end
    end
    #1;
    do_reset();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Write then read back through the other port; port 0 wins the first tie.
    for (int d = 0; d < 2; d++) begin
      push(d, 0, 1'b1, 9'h005, 16'hBEEF, 0);
      push(d, 1, 1'b0, 9'h005, 16'h0000, 0);
    end
    drain("drain_basic", 50);

    // Both ports held with back-to-back reads.
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        push(d, 0, 1'b0, 9'(k),      16'h0, 0);
        push(d, 1, 1'b0, 9'(k + 16), 16'h0, 0);
      end
    drain("drain_contend", 100);

    // Out-of-range write and read.
    for (int d = 0; d < 2; d++) begin
      push(d, 0, 1'b1, 9'h1A0, 16'h1234, 0);
      push(d, 0, 1'b0, 9'h1A0, 16'h0000, 0);
    end
    drain("drain_oor", 50);

    // Reset in the middle of a read, with rdata previously non-zero.
    for (int d = 0; d < 2; d++) push(d, 0, 1'b0, 9'h005, 16'h0, 0);
    drain("drain_preload", 50);
    for (int d = 0; d < 2; d++) push(d, 0, 1'b0, 9'h005, 16'h0, 0);
    for (int k = 0; k < 20 && ph[0] != 2; k++) @(negedge clk);
    check("reach_rd_d", 32'(ph[0]), 32'd2);
    #2;
    do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      push(d, 0, 1'b0, 9'h005, 16'h0, 0);
      push(d, 1, 1'b0, 9'h006, 16'h0, 0);
    end
    drain("drain_after_rst", 50);

    // Randomized traffic with random gaps and occasional out-of-range addresses.
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < 40; k++)
          push(d, p, 1'($urandom_range(0, 1)),
               {($urandom_range(0, 3) == 0), 8'($urandom)},
               16'($urandom), $urandom_range(0, 3));
    drain("drain_random", 3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
